// File: rtl/output_array_pkg.sv
// +--------------------------------------------------------------------------+
// | output_array_pkg: press codes, glyphs and FSM encoding for output_array  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package output_array_pkg;

  localparam logic [2:0] NXT  = 3'b000;
  localparam logic [2:0] RLS  = 3'b001;
  localparam logic [2:0] CON  = 3'b010;
  localparam logic [2:0] DEL  = 3'b011;
  localparam logic [2:0] RIS  = 3'b100;
  localparam logic [2:0] NONE = 3'b111;

  localparam logic [4:0] EMPTY_VAL = 5'd31;

  localparam logic [7:0] GLYPH_0     = 8'hC0;
  localparam logic [7:0] GLYPH_1     = 8'hF9;
  localparam logic [7:0] GLYPH_2     = 8'hA4;
  localparam logic [7:0] GLYPH_3     = 8'hB0;
  localparam logic [7:0] GLYPH_4     = 8'h99;
  localparam logic [7:0] GLYPH_5     = 8'h92;
  localparam logic [7:0] GLYPH_6     = 8'h82;
  localparam logic [7:0] GLYPH_7     = 8'hF8;
  localparam logic [7:0] GLYPH_DASH  = 8'hBF;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;

  // Digit code 0..7 renders as a numeral; anything else renders as '-'
  localparam logic [3:0] CODE_DASH = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BROWSE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  function automatic logic [7:0] glyph(input logic [3:0] code);
    case (code)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      default: return GLYPH_DASH;
    endcase
  endfunction

  // Entry 0 sits in the most significant slot of the packed array
  function automatic logic [4:0] entry_at(input logic [19:0] arr, input logic [1:0] k);
    case (k)
      2'd0:    return arr[19:15];
      2'd1:    return arr[14:10];
      2'd2:    return arr[9:5];
      default: return arr[4:0];
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/output_array_seg7_scan.sv
// +--------------------------------------------------------------------------+
// | seg7_scan: two-digit multiplexed 7-segment driver (value on digit 0,     |
// | index on digit 7). Revision: 1.0                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg7_scan
  import output_array_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active,
  input  logic [3:0] val_code,
  input  logic [3:0] idx_code,
  output logic [7:0] seg_an,
  output logic [7:0] seg_data
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sel <= 1'b0;
    end else if (!active) begin
      r_cnt <= '0;
      r_sel <= 1'b0;
    end else if (r_cnt == C_CNT_MAX) begin
      r_cnt <= '0;
      r_sel <= ~r_sel;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    seg_an   = 8'hFF;
    seg_data = GLYPH_BLANK;
    if (active) begin
      if (r_sel) begin
        seg_an   = 8'h7F;
        seg_data = glyph(idx_code);
      end else begin
        seg_an   = 8'hFE;
        seg_data = glyph(val_code);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/output_array.sv
// +--------------------------------------------------------------------------+
// | output_array: browse a packed 4-entry array with push-button codes,      |
// | show the selection on LEDs and 7-seg, pulse over on confirm. Rev: 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module output_array
  import output_array_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [2:0]  press,
  input  logic [19:0] array_in,
  input  logic [3:0]  count,
  output logic        over,
  output logic [1:0]  idx,
  output logic [7:0]  led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_data
);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic       w_over_nxt;
  logic [2:0] w_cnt_eff;
  logic [1:0] w_last;
  logic [4:0] w_val;
  logic       w_dash;
  logic [3:0] r_val_code;

  assign w_cnt_eff = (count > 4'd4) ? 3'd4 : count[2:0];
  assign w_last    = 2'(w_cnt_eff - 3'd1);
  assign idx       = r_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_over_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idx_nxt = 2'd0;
        if (en) w_state_nxt = ST_BROWSE;
      end
      ST_BROWSE: begin
        if (w_cnt_eff == 3'd0) begin
          w_idx_nxt = 2'd0;
          if (press == CON) begin
            w_over_nxt  = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end else if ({1'b0, r_idx} >= w_cnt_eff) begin
          // A shrinking count wins over whatever was pressed this cycle
          w_idx_nxt = 2'd0;
        end else begin
          case (press)
            NXT: w_idx_nxt = (r_idx == w_last) ? 2'd0 : r_idx + 2'd1;
            RIS: w_idx_nxt = (r_idx == 2'd0) ? w_last : r_idx - 2'd1;
            RLS: w_idx_nxt = 2'd0;
            CON: begin
              w_over_nxt  = 1'b1;
              w_state_nxt = ST_HOLD;
            end
            DEL, NONE: ;
            default: ;
          endcase
        end
      end
      ST_HOLD: ;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = 2'd0;
      w_over_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      over    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      over    <= w_over_nxt;
    end
  end

  assign w_val  = entry_at(array_in, r_idx);
  assign w_dash = (w_cnt_eff == 3'd0) || (w_val == EMPTY_VAL) || (w_val > 5'd7);

  // Display path lags idx by one edge; blanks as soon as IDLE is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led        <= 8'h00;
      r_val_code <= CODE_DASH;
    end else begin
      if (w_state_nxt == ST_IDLE || w_dash) led <= 8'h00;
      else                                  led <= 8'h01 << w_val[2:0];
      r_val_code <= w_dash ? CODE_DASH : {1'b0, w_val[2:0]};
    end
  end

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (r_state != ST_IDLE),
    .val_code(r_val_code),
    .idx_code({2'b00, r_idx}),
    .seg_an  (seg_an),
    .seg_data(seg_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_output_array.sv
// +--------------------------------------------------------------------------+
// | tb_output_array: vector table with expectation queue plus hand-written   |
// | scan, dash and async-reset sequences. Revision: 1.0                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_output_array;

  localparam logic [2:0] P_NXT = 3'b000, P_RLS = 3'b001, P_CON = 3'b010;
  localparam logic [2:0] P_DEL = 3'b011, P_RIS = 3'b100, P_NONE = 3'b111;
  localparam int NV = 27;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [2:0]  press;
  logic [19:0] array_in;
  logic [3:0]  count;
  logic        over;
  logic [1:0]  idx;
  logic [7:0]  led, seg_an, seg_data;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       en;
    logic [2:0] press;
    logic [3:0] count;
    logic [1:0] idx;
    logic [7:0] led;
    logic       over;
  } vec_t;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] led;
    logic       over;
    logic       blank;
  } exp_t;

  vec_t vt[NV];
  exp_t sb[$];

  output_array #(.SCAN_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .press   (press),
    .array_in(array_in),
    .count   (count),
    .over    (over),
    .idx     (idx),
    .led     (led),
    .seg_an  (seg_an),
    .seg_data(seg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    logic found;

    vt[0]  = '{1'b1, P_NXT,  4'd2, 2'd1, 8'h08, 1'b0};
    vt[1]  = '{1'b1, P_NONE, 4'd2, 2'd1, 8'h80, 1'b0};
    vt[2]  = '{1'b1, P_NXT,  4'd2, 2'd0, 8'h80, 1'b0};
    vt[3]  = '{1'b1, P_NONE, 4'd2, 2'd0, 8'h08, 1'b0};
    vt[4]  = '{1'b1, P_RIS,  4'd2, 2'd1, 8'h08, 1'b0};
    vt[5]  = '{1'b1, P_NONE, 4'd2, 2'd1, 8'h80, 1'b0};
    vt[6]  = '{1'b1, P_RLS,  4'd2, 2'd0, 8'h80, 1'b0};
    vt[7]  = '{1'b1, P_DEL,  4'd2, 2'd0, 8'h08, 1'b0};
    vt[8]  = '{1'b1, P_NXT,  4'd2, 2'd1, 8'h08, 1'b0};
    vt[9]  = '{1'b1, P_NXT,  4'd1, 2'd0, 8'h80, 1'b0};  // shrink beats nxt
    vt[10] = '{1'b1, P_NONE, 4'd1, 2'd0, 8'h08, 1'b0};
    vt[11] = '{1'b1, P_NXT,  4'd7, 2'd1, 8'h08, 1'b0};  // count clamps to 4
    vt[12] = '{1'b1, P_NXT,  4'd7, 2'd2, 8'h80, 1'b0};
    vt[13] = '{1'b1, P_NXT,  4'd7, 2'd3, 8'h00, 1'b0};
    vt[14] = '{1'b1, P_NXT,  4'd7, 2'd0, 8'h00, 1'b0};
    vt[15] = '{1'b1, P_RIS,  4'd7, 2'd3, 8'h08, 1'b0};
    vt[16] = '{1'b1, P_CON,  4'd7, 2'd3, 8'h00, 1'b1};
    vt[17] = '{1'b1, P_NXT,  4'd7, 2'd3, 8'h00, 1'b0};  // HOLD ignores presses
    vt[18] = '{1'b1, P_RLS,  4'd7, 2'd3, 8'h00, 1'b0};
    vt[19] = '{1'b0, P_NONE, 4'd7, 2'd0, 8'h00, 1'b0};
    vt[20] = '{1'b1, P_NXT,  4'd2, 2'd0, 8'h08, 1'b0};  // press on entry ignored
    vt[21] = '{1'b1, P_NXT,  4'd0, 2'd0, 8'h00, 1'b0};
    vt[22] = '{1'b1, P_RIS,  4'd0, 2'd0, 8'h00, 1'b0};
    vt[23] = '{1'b1, P_RLS,  4'd0, 2'd0, 8'h00, 1'b0};
    vt[24] = '{1'b1, P_CON,  4'd0, 2'd0, 8'h00, 1'b1};
    vt[25] = '{1'b1, P_NONE, 4'd0, 2'd0, 8'h00, 1'b0};
    vt[26] = '{1'b0, P_NONE, 4'd0, 2'd0, 8'h00, 1'b0};

    rst_n    = 1'b0;
    en       = 1'b0;
    press    = P_NONE;
    array_in = {5'd3, 5'd7, 5'd31, 5'd31};
    count    = 4'd2;

    #12;
    chk("rst_over", {7'b0, over}, 8'h00);
    chk("rst_idx", {6'b0, idx}, 8'h00);
    chk("rst_led", led, 8'h00);
    chk("rst_an", seg_an, 8'hFF);
    chk("rst_seg", seg_data, 8'hFF);

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // Value 3 on digit 0 and index 0 on digit 7, four cycles each
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("scan%0d_an", i), seg_an, (i < 4) ? 8'hFE : 8'h7F);
      chk($sformatf("scan%0d_seg", i), seg_data, (i < 4) ? 8'hB0 : 8'hC0);
      if (i == 0) begin
        chk("start_idx", {6'b0, idx}, 8'h00);
        chk("start_led", led, 8'h08);
      end
    end

    for (int i = 0; i < NV; i++) begin
      en    = vt[i].en;
      press = vt[i].press;
      count = vt[i].count;
      sb.push_back('{vt[i].idx, vt[i].led, vt[i].over, !vt[i].en});
      @(negedge clk);
      press = P_NONE;
      e = sb.pop_front();
      chk($sformatf("v%0d_idx", i), {6'b0, idx}, {6'b0, e.idx});
      chk($sformatf("v%0d_led", i), led, e.led);
      chk($sformatf("v%0d_over", i), {7'b0, over}, {7'b0, e.over});
      if (e.blank) chk($sformatf("v%0d_an", i), seg_an, 8'hFF);
    end

    // No valid entries: value digit shows a dash
    en    = 1'b1;
    count = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (seg_an == 8'hFE) found = 1'b1;
    end
    chk("dash_an", seg_an, 8'hFE);
    chk("dash_seg", seg_data, 8'hBF);

    // Into HOLD at idx 1, then asynchronous reset between edges
    count = 4'd2;
    press = P_NXT;
    @(negedge clk);
    press = P_NONE;
    chk("pre_idx", {6'b0, idx}, 8'h01);
    press = P_CON;
    @(negedge clk);
    press = P_NONE;
    chk("con_over", {7'b0, over}, 8'h01);
    @(negedge clk);
    chk("con_over_drop", {7'b0, over}, 8'h00);
    chk("hold_led", led, 8'h80);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_idx", {6'b0, idx}, 8'h00);
    chk("arst_led", led, 8'h00);
    chk("arst_over", {7'b0, over}, 8'h00);
    chk("arst_an", seg_an, 8'hFF);
    chk("arst_seg", seg_data, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("resume_idx", {6'b0, idx}, 8'h00);
    chk("resume_led", led, 8'h08);
    press = P_NXT;
    @(negedge clk);
    press = P_NONE;
    chk("resume_nxt", {6'b0, idx}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
